// File: rtl/fetch_unit_if.sv
// ------------------------------------------------------------------
// fetch_unit_if: fetch control, instruction memory and IF/ID bundle.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface fetch_unit_if;
  logic        PCLocker;
  logic        IF_IDLocker;
  logic        redirectValid;
  logic [31:0] redirectPC;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;

  modport master (
    input  PCLocker, IF_IDLocker, redirectValid, redirectPC,
    input  imem_ready, imem_rvalid, imem_rdata,
    output imem_req, imem_addr,
    output ifid_valid, ifid_pc, ifid_instr
  );

  modport slave (
    output PCLocker, IF_IDLocker, redirectValid, redirectPC,
    output imem_ready, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr,
    input  ifid_valid, ifid_pc, ifid_instr
  );
endinterface

`default_nettype wire

// File: rtl/fetch_unit.sv
// ------------------------------------------------------------------
// fetch_unit: single-outstanding instruction fetch with 1-entry skid
// buffer feeding the IF/ID pipeline register. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  wire logic        clk,
  input  wire logic        rst,
  fetch_unit_if.master     bus
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  localparam logic [31:0] c_ALIGN_MASK = 32'hFFFF_FFFC;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        drop_q, drop_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;

  logic        fetch_req;
  logic        fetch_accept;
  logic        deliver;
  logic [31:0] dlv_pc;
  logic [31:0] dlv_instr;

  // A redirect suppresses the request so the stale pc is never fetched.
  assign fetch_req    = (state_q == S_FETCH) && bus.PCLocker && !bus.redirectValid && !rst;
  assign fetch_accept = fetch_req && bus.imem_ready;

  assign bus.imem_req   = fetch_req;
  assign bus.imem_addr  = pc_q & c_ALIGN_MASK;
  assign bus.ifid_valid = ifid_valid_q;
  assign bus.ifid_pc    = ifid_pc_q;
  assign bus.ifid_instr = ifid_instr_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    drop_d       = drop_q;
    buf_pc_d     = buf_pc_q;
    buf_instr_d  = buf_instr_q;
    ifid_valid_d = ifid_valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    deliver      = 1'b0;
    dlv_pc       = req_pc_q;
    dlv_instr    = bus.imem_rdata;

    if (bus.redirectValid) begin
      pc_d         = bus.redirectPC & c_ALIGN_MASK;
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP_INSTR;
      state_d      = S_FETCH;
      drop_d       = 1'b0;
      // Response still in flight: remember to swallow it when it lands.
      if ((state_q == S_WAIT) && !bus.imem_rvalid) begin
        state_d = S_WAIT;
        drop_d  = 1'b1;
      end
    end else begin
      case (state_q)
        S_FETCH: begin
          if (fetch_accept) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + 32'd4;
            state_d  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.imem_rvalid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = S_FETCH;
            end else if (bus.IF_IDLocker) begin
              deliver = 1'b1;
              state_d = S_FETCH;
            end else begin
              buf_pc_d    = req_pc_q;
              buf_instr_d = bus.imem_rdata;
              state_d     = S_FULL;
            end
          end
        end
        S_FULL: begin
          if (bus.IF_IDLocker) begin
            deliver   = 1'b1;
            dlv_pc    = buf_pc_q;
            dlv_instr = buf_instr_q;
            state_d   = S_FETCH;
          end
        end
        default: state_d = S_FETCH;
      endcase

      if (bus.IF_IDLocker) begin
        ifid_valid_d = deliver;
        ifid_pc_d    = deliver ? dlv_pc : ifid_pc_q;
        ifid_instr_d = deliver ? dlv_instr : NOP_INSTR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      req_pc_q     <= 32'h0;
      drop_q       <= 1'b0;
      buf_pc_q     <= 32'h0;
      buf_instr_q  <= 32'h0;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= 32'h0;
      ifid_instr_q <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      drop_q       <= drop_d;
      buf_pc_q     <= buf_pc_d;
      buf_instr_q  <= buf_instr_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ------------------------------------------------------------------
// tb_fetch_unit: scenario tasks plus a delivery scoreboard for fetch_unit.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_fetch_unit;

  localparam logic [31:0] c_NOP    = 32'h0000_0013;
  localparam logic [31:0] c_RST_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   mem_lat;
  exp_t exp_q[$];

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(c_RST_PC), .NOP_INSTR(c_NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return ~a ^ 32'h0F0F_0000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = instr_of(pc);
    exp_q.push_back(e);
  endtask

  // Memory model: responds mem_lat cycles after an accepted request.
  initial begin
    logic        acc;
    logic [31:0] a;
    logic        pend;
    logic [31:0] pend_addr;
    int          pend_wait;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    pend = 1'b0; pend_addr = 32'h0; pend_wait = 0;
    forever begin
      @(negedge clk);
      acc = bus.imem_req && bus.imem_ready && !rst;
      a   = bus.imem_addr;
      @(posedge clk);
      #1;
      bus.imem_rvalid = 1'b0;
      if (acc) begin
        pend = 1'b1; pend_addr = a; pend_wait = mem_lat;
      end
      if (pend) begin
        pend_wait = pend_wait - 1;
        if (pend_wait == 0) begin
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata  = instr_of(pend_addr);
          pend = 1'b0;
        end
      end
    end
  end

  // Scoreboard: every new valid IF/ID entry must match the queue head.
  initial begin
    logic        pv;
    logic [31:0] pp;
    logic [31:0] pi;
    exp_t        e;
    pv = 1'b0; pp = 32'h0; pi = 32'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0;
      end else begin
        if (bus.ifid_valid && (!pv || bus.ifid_pc !== pp || bus.ifid_instr !== pi)) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL sb_unexpected: got pc=%h instr=%h, required no delivery",
                     bus.ifid_pc, bus.ifid_instr);
          end else begin
            e = exp_q.pop_front();
            if ({bus.ifid_pc, bus.ifid_instr} !== {e.pc, e.instr}) begin
              n_errors++;
              $display("FAIL sb_delivery: got pc=%h instr=%h, required pc=%h instr=%h",
                       bus.ifid_pc, bus.ifid_instr, e.pc, e.instr);
            end
          end
        end
        pv = bus.ifid_valid; pp = bus.ifid_pc; pi = bus.ifid_instr;
      end
    end
  end

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      tick();
      k++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL %s_drain: got %0d deliveries outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.PCLocker = 1'b1; bus.IF_IDLocker = 1'b1;
    bus.redirectValid = 1'b0; bus.redirectPC = 32'h0;
    bus.imem_ready = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    n_checks++;
    if (bus.imem_req !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_req: got %b, required 0", bus.imem_req);
    end
    n_checks++;
    if ({bus.ifid_valid, bus.ifid_pc, bus.ifid_instr} !== {1'b0, 32'h0, c_NOP}) begin
      n_errors++;
      $display("FAIL rst_ifid: got v=%b pc=%h i=%h, required v=0 pc=0 i=%h",
               bus.ifid_valid, bus.ifid_pc, bus.ifid_instr, c_NOP);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_sequence();
    logic        er, ev;
    logic [31:0] ea, ep, ei;
    push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      er = (i % 2 == 0) && (i <= 4);
      ea = 32'(4 * (i / 2));
      ev = (i % 2 == 0) && (i >= 2);
      ep = (i < 2) ? 32'h0 : 32'(4 * ((i - 2) / 2));
      ei = ev ? instr_of(ep) : c_NOP;
      n_checks++;
      if (bus.imem_req !== er || (er && bus.imem_addr !== ea)) begin
        n_errors++;
        $display("FAIL seq_req[%0d]: got req=%b addr=%h, required req=%b addr=%h",
                 i, bus.imem_req, bus.imem_addr, er, ea);
      end
      n_checks++;
      if ({bus.ifid_valid, bus.ifid_pc, bus.ifid_instr} !== {ev, ep, ei}) begin
        n_errors++;
        $display("FAIL seq_ifid[%0d]: got v=%b pc=%h i=%h, required v=%b pc=%h i=%h",
                 i, bus.ifid_valid, bus.ifid_pc, bus.ifid_instr, ev, ep, ei);
      end
      tick();
      if (i == 4) bus.PCLocker = 1'b0;
    end
    drain("seq");
  endtask

  task automatic test_pclocker();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'hC) begin
        n_errors++;
        $display("FAIL pcl_hold[%0d]: got req=%b addr=%h, required req=0 addr=0000000c",
                 i, bus.imem_req, bus.imem_addr);
      end
      tick();
    end
    bus.PCLocker = 1'b1;
    push_exp(32'hC);
    @(negedge clk);
    n_checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hC) begin
      n_errors++;
      $display("FAIL pcl_resume: got req=%b addr=%h, required req=1 addr=0000000c",
               bus.imem_req, bus.imem_addr);
    end
    tick();
    bus.PCLocker = 1'b0;
    drain("pcl");
  endtask

  task automatic test_iflocker();
    logic        er, ck, ev;
    logic [31:0] ea, ep, ei;
    push_exp(32'h10); push_exp(32'h14);
    bus.PCLocker = 1'b1;
    for (int s = 0; s < 8; s++) begin
      @(negedge clk);
      er = (s == 0) || (s == 2);
      ea = (s == 0) ? 32'h10 : 32'h14;
      ck = (s >= 2);
      ev = (s >= 2) && (s <= 6);
      ep = (s <= 5) ? 32'h10 : 32'h14;
      ei = (s == 7) ? c_NOP : instr_of(ep);
      n_checks++;
      if (bus.imem_req !== er || (er && bus.imem_addr !== ea)) begin
        n_errors++;
        $display("FAIL ifl_req[%0d]: got req=%b addr=%h, required req=%b addr=%h",
                 s, bus.imem_req, bus.imem_addr, er, ea);
      end
      if (ck) begin
        n_checks++;
        if ({bus.ifid_valid, bus.ifid_pc, bus.ifid_instr} !== {ev, ep, ei}) begin
          n_errors++;
          $display("FAIL ifl_ifid[%0d]: got v=%b pc=%h i=%h, required v=%b pc=%h i=%h",
                   s, bus.ifid_valid, bus.ifid_pc, bus.ifid_instr, ev, ep, ei);
        end
      end
      tick();
      if (s == 1) bus.IF_IDLocker = 1'b0;
      if (s == 4) bus.IF_IDLocker = 1'b1;
      if (s == 5) bus.PCLocker = 1'b0;
    end
    drain("ifl");
  endtask

  task automatic test_redirect_wait();
    logic        er;
    logic [31:0] ea;
    push_exp(32'h100);
    mem_lat = 3;
    bus.PCLocker = 1'b1;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      er = (s == 0) || (s == 4);
      ea = (s == 0) ? 32'h18 : 32'h100;
      n_checks++;
      if (bus.imem_req !== er || (er && bus.imem_addr !== ea)) begin
        n_errors++;
        $display("FAIL rdw_req[%0d]: got req=%b addr=%h, required req=%b addr=%h",
                 s, bus.imem_req, bus.imem_addr, er, ea);
      end
      if (s >= 2) begin
        n_checks++;
        if ({bus.ifid_valid, bus.ifid_pc, bus.ifid_instr} !== {1'b0, 32'h14, c_NOP}) begin
          n_errors++;
          $display("FAIL rdw_ifid[%0d]: got v=%b pc=%h i=%h, required v=0 pc=00000014 i=%h",
                   s, bus.ifid_valid, bus.ifid_pc, bus.ifid_instr, c_NOP);
        end
      end
      tick();
      if (s == 0) begin bus.redirectValid = 1'b1; bus.redirectPC = 32'h103; end
      if (s == 1) bus.redirectValid = 1'b0;
      if (s == 2) mem_lat = 1;
      if (s == 4) bus.PCLocker = 1'b0;
    end
    drain("rdw");
  endtask

  task automatic test_wrap();
    logic        er;
    logic [31:0] ea;
    push_exp(32'hFFFF_FFFC); push_exp(32'h0);
    bus.redirectValid = 1'b1; bus.redirectPC = 32'hFFFF_FFFC;
    bus.PCLocker = 1'b1;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      er = (s == 1) || (s == 3);
      ea = (s == 1) ? 32'hFFFF_FFFC : 32'h0;
      n_checks++;
      if (bus.imem_req !== er || (er && bus.imem_addr !== ea)) begin
        n_errors++;
        $display("FAIL wrap_req[%0d]: got req=%b addr=%h, required req=%b addr=%h",
                 s, bus.imem_req, bus.imem_addr, er, ea);
      end
      tick();
      if (s == 0) bus.redirectValid = 1'b0;
      if (s == 3) bus.PCLocker = 1'b0;
    end
    drain("wrap");
  endtask

  task automatic test_redirect_full();
    logic        er;
    logic [31:0] ea;
    bus.IF_IDLocker = 1'b0;
    bus.PCLocker = 1'b1;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      er = (s == 0) || (s == 4);
      ea = (s == 0) ? 32'h4 : 32'h200;
      n_checks++;
      if (bus.imem_req !== er || ((er || s == 3) && bus.imem_addr !== ea)) begin
        n_errors++;
        $display("FAIL rdf_req[%0d]: got req=%b addr=%h, required req=%b addr=%h",
                 s, bus.imem_req, bus.imem_addr, er, ea);
      end
      if (s == 3) begin
        n_checks++;
        if (bus.ifid_valid !== 1'b0 || bus.ifid_instr !== c_NOP) begin
          n_errors++;
          $display("FAIL rdf_bubble: got v=%b i=%h, required v=0 i=%h",
                   bus.ifid_valid, bus.ifid_instr, c_NOP);
        end
      end
      tick();
      if (s == 1) begin
        bus.redirectValid = 1'b1; bus.redirectPC = 32'h200; bus.PCLocker = 1'b0;
      end
      if (s == 2) bus.redirectValid = 1'b0;
      if (s == 3) begin bus.IF_IDLocker = 1'b1; bus.PCLocker = 1'b1; push_exp(32'h200); end
      if (s == 4) bus.PCLocker = 1'b0;
    end
    drain("rdf");
  endtask

  task automatic test_reset_mid();
    logic        er;
    logic [31:0] ea;
    mem_lat = 3;
    bus.PCLocker = 1'b1;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      er = (s == 0) || (s == 4);
      ea = (s == 0) ? 32'h204 : c_RST_PC;
      n_checks++;
      if (bus.imem_req !== er || ((er || s == 2) && bus.imem_addr !== ea)) begin
        n_errors++;
        $display("FAIL rmid_req[%0d]: got req=%b addr=%h, required req=%b addr=%h",
                 s, bus.imem_req, bus.imem_addr, er, ea);
      end
      if (s >= 2) begin
        n_checks++;
        if ({bus.ifid_valid, bus.ifid_pc, bus.ifid_instr} !== {1'b0, 32'h0, c_NOP}) begin
          n_errors++;
          $display("FAIL rmid_ifid[%0d]: got v=%b pc=%h i=%h, required v=0 pc=0 i=%h",
                   s, bus.ifid_valid, bus.ifid_pc, bus.ifid_instr, c_NOP);
        end
      end
      tick();
      if (s == 0) rst = 1'b1;
      if (s == 1) begin rst = 1'b0; bus.PCLocker = 1'b0; end
      if (s == 3) begin mem_lat = 1; bus.PCLocker = 1'b1; push_exp(c_RST_PC); end
      if (s == 4) bus.PCLocker = 1'b0;
    end
    drain("rmid");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    mem_lat  = 1;
    test_reset();
    test_sequence();
    test_pclocker();
    test_iflocker();
    test_redirect_wait();
    test_wrap();
    test_redirect_full();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
